byte_word_assembler: RTL
========================

Name: byte_word_assembler

Overview:
- Byte-stream to word deserializer for boot/peripheral paths, e.g. UART or SPI-flash loader feeding the memory bus.
- Accepts one byte per cycle over a valid/ready handshake and packs N_BYTES bytes into one bus word.
- Lane order is little- or big-endian, selectable per word.
- Double-buffered (accumulator plus output register) to sustain 1 byte/cycle; supports flush of partial words with byte strobes.

Parameters:
- N_BYTES, 4, bytes per output word; legal values 2..8.
- N_BITS, N_BYTES*8, output word width; derived, not overridden.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- big_endian  input  1  lane order for the next word; 1 = first byte to MSB lane.
- byte_in  input  8  incoming byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  block can accept a byte this cycle.
- flush  input  1  emit accumulated partial word (single-cycle pulse).
- word_out  output  N_BITS  assembled word.
- word_strb  output  N_BYTES  per-lane valid strobes for word_out.
- word_valid  output  1  word_out/word_strb valid.
- word_ready  input  1  consumer accepts the word this cycle.
- byte_cnt  output  $clog2(N_BYTES+1)  bytes currently in the accumulator.

Behaviour:
- Async reset (nRST low) clears state immediately, including mid-word; partial data is discarded. Reset values:
  - word_out=0, word_strb=0, word_valid=0, byte_cnt=0.
  - Accumulator state FILL; byte_ready=1.
- Accept event: byte_valid && byte_ready at a rising edge. Output transfer: word_valid && word_ready at a rising edge.
- Lane mapping for the k-th byte of a word (k = 0..N_BYTES-1):
  - Little-endian: lane k, bits [8k+7:8k].
  - Big-endian: lane N_BYTES-1-k.
  - Unfilled lanes are 0 with strobe 0.
- big_endian is latched when k=0 is accepted. Later changes within that word have no effect.
- Accumulator states:
  - FILL: byte_ready=1. Accept event writes the lane, sets its strobe, increments byte_cnt.
  - PENDING: the accumulator holds a complete or flushed word that the output register cannot yet take. byte_ready=0; flush is ignored.
- Word close: on the accept of byte k=N_BYTES-1, or flush with byte_cnt>0, or flush coinciding with an accept (that byte is included first).
- Handoff at a close edge:
  - If the output register is empty, or a transfer occurs that same edge, the word moves to the output register. word_valid=1 on the next cycle, so latency is 1 cycle from the final accept.
  - The accumulator clears: byte_cnt=0, strobes=0, state stays FILL.
  - Otherwise the accumulator enters PENDING.
- PENDING exits on the edge where a transfer occurs. The accumulator moves to the output register, word_valid stays 1, and the state returns to FILL with byte_cnt=0. byte_ready=1 again the following cycle.
- Flush with byte_cnt=0 and no coincident accept: no-op, no empty word is emitted.
- Output stability: word_out and word_strb stay constant while word_valid=1 && word_ready=0. word_valid drops on transfer unless a new word loads on the same edge.
- Throughput: 1 byte/cycle sustained when word_ready is held 1. No bubble between words.
- byte_cnt reads N_BYTES only in PENDING for a full word. In PENDING after a flush it reads the partial count.

Decomposition:
- Shared package (bus_util_pkg):
  - BYTE_W=8.
  - Endianness typedef: enum logic {LITTLE=0, BIG=1}.
  - Accumulator state typedef: enum {FILL, PENDING}.
- One sub-module, byte_lane_sel. Combinational: (byte index, endianness) to one-hot N_BYTES lane enable. It is reused by the future word-to-byte serializer.

Test Plan:
- Reset, then little-endian bytes 0x11,0x22,0x33,0x44 on consecutive cycles with word_ready=1 -> word_out=0x44332211 and word_strb=4'b1111, word_valid=1 exactly one cycle after the 0x44 accept.
- Same bytes with big_endian=1 at the first byte, then toggled to 0 mid-word -> word_out=0x11223344.
- 0xAA,0xBB then flush alone (LE) -> word_out=0x0000BBAA, word_strb=4'b0011. A flush with byte_cnt=0 -> no word_valid.
- word_ready=0, stream 8 bytes 0x01..0x08 (LE):
  - First word 0x04030201 is held stable; the second word fills and byte_ready drops after 0x08.
  - Raise word_ready -> 0x08070605 is presented next cycle with no data loss.
  - byte_ready returns to 1.
- Flush in the same cycle as an accept of the 3rd byte 0xCC after 0xAA,0xBB (LE) -> single word 0x00CCBBAA, strb 4'b0111.
- nRST pulsed low after 2 bytes while a word is held -> outputs go to their reset values immediately. The next 4 bytes form a clean word with no leftover lanes.

Source files
------------

// File: rtl/bus_util_pkg.sv
// Shared types for the byte/word bus utilities: byte width, lane order and
// accumulator state encodings.
package bus_util_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    LITTLE = 1'b0,
    BIG    = 1'b1
  } endian_e;

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } acc_state_e;

endpackage

// File: rtl/byte_word_assembler_if.sv
// Byte-in / word-out handshake bundle for the byte-to-word assembler.
interface byte_word_assembler_if
  import bus_util_pkg::*;
#(
  parameter int unsigned N_BYTES = 4
) ();

  localparam int unsigned N_BITS = N_BYTES * BYTE_W;
  localparam int unsigned CNT_W  = $clog2(N_BYTES + 1);

  logic              big_endian;
  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              flush;
  logic [N_BITS-1:0] word_out;
  logic [N_BYTES-1:0] word_strb;
  logic              word_valid;
  logic              word_ready;
  logic [CNT_W-1:0]  byte_cnt;

  // Producer of bytes / consumer of words
  modport master (
    output big_endian, byte_in, byte_valid, flush, word_ready,
    input  byte_ready, word_out, word_strb, word_valid, byte_cnt
  );

  // The assembler itself
  modport slave (
    input  big_endian, byte_in, byte_valid, flush, word_ready,
    output byte_ready, word_out, word_strb, word_valid, byte_cnt
  );

endinterface

// File: rtl/byte_lane_sel.sv
// Maps a byte index within a word plus lane order to a one-hot lane enable.
// Shared with the word-to-byte serializer.
module byte_lane_sel
  import bus_util_pkg::*;
#(
  parameter  int unsigned N_BYTES = 4,
  localparam int unsigned IDX_W   = $clog2(N_BYTES)
) (
  input  logic [IDX_W-1:0]   i_idx,
  input  endian_e            i_endian,
  output logic [N_BYTES-1:0] o_lane_en_c
);

  logic [IDX_W-1:0] w_lane;

  assign w_lane      = (i_endian == BIG) ? (IDX_W'(N_BYTES - 1) - i_idx) : i_idx;
  assign o_lane_en_c = N_BYTES'(1) << w_lane;

endmodule

// File: rtl/byte_word_assembler.sv
// Byte-stream to word deserializer: accumulator plus output register so a
// full word can wait for the consumer while the next one fills.
module byte_word_assembler
  import bus_util_pkg::*;
#(
  parameter int unsigned N_BYTES = 4
) (
  input logic                  CLK,
  input logic                  nRST,
  byte_word_assembler_if.slave bus
);

  localparam int unsigned N_BITS = N_BYTES * BYTE_W;
  localparam int unsigned CNT_W  = $clog2(N_BYTES + 1);
  localparam int unsigned IDX_W  = $clog2(N_BYTES);

  acc_state_e         r_state;
  endian_e            r_endian;
  logic [N_BITS-1:0]  r_acc_data;
  logic [N_BYTES-1:0] r_acc_strb;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_BITS-1:0]  r_out_data;
  logic [N_BYTES-1:0] r_out_strb;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_xfer;
  logic               w_out_free;
  logic               w_close;
  endian_e            w_endian;
  logic [N_BYTES-1:0] w_lane_en;
  logic [N_BITS-1:0]  w_acc_data;
  logic [N_BYTES-1:0] w_acc_strb;
  logic [CNT_W-1:0]   w_cnt;

  assign w_accept   = bus.byte_valid && (r_state == FILL);
  assign w_xfer     = r_out_valid && bus.word_ready;
  assign w_out_free = !r_out_valid || w_xfer;

  // Lane order is sampled on the first byte and held for the rest of the word
  assign w_endian = (r_cnt == '0) ? endian_e'(bus.big_endian) : r_endian;

  byte_lane_sel #(
    .N_BYTES (N_BYTES)
  ) u_lane_sel (
    .i_idx       (IDX_W'(r_cnt)),
    .i_endian    (w_endian),
    .o_lane_en_c (w_lane_en)
  );

  // Accumulator contents including the byte accepted this cycle
  always_comb begin
    w_acc_data = r_acc_data;
    w_acc_strb = r_acc_strb;
    w_cnt      = r_cnt;
    if (w_accept) begin
      for (int i = 0; i < N_BYTES; i++) begin
        if (w_lane_en[i]) w_acc_data[i*BYTE_W +: BYTE_W] = bus.byte_in;
      end
      w_acc_strb = r_acc_strb | w_lane_en;
      w_cnt      = r_cnt + CNT_W'(1);
    end
  end

  // A coincident accept is folded into the word before a flush closes it
  assign w_close = (r_state == FILL) &&
                   ((w_accept && (r_cnt == CNT_W'(N_BYTES - 1))) ||
                    (bus.flush && ((r_cnt != '0) || w_accept)));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= FILL;
      r_endian    <= LITTLE;
      r_acc_data  <= '0;
      r_acc_strb  <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_strb  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_xfer) r_out_valid <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_accept && (r_cnt == '0)) r_endian <= w_endian;
          if (w_close && w_out_free) begin
            r_out_data  <= w_acc_data;
            r_out_strb  <= w_acc_strb;
            r_out_valid <= 1'b1;
            r_acc_data  <= '0;
            r_acc_strb  <= '0;
            r_cnt       <= '0;
          end else begin
            r_acc_data <= w_acc_data;
            r_acc_strb <= w_acc_strb;
            r_cnt      <= w_cnt;
            if (w_close) r_state <= PENDING;
          end
        end
        PENDING: begin
          if (w_xfer) begin
            r_out_data  <= r_acc_data;
            r_out_strb  <= r_acc_strb;
            r_out_valid <= 1'b1;
            r_acc_data  <= '0;
            r_acc_strb  <= '0;
            r_cnt       <= '0;
            r_state     <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.byte_ready = (r_state == FILL);
  assign bus.word_out   = r_out_data;
  assign bus.word_strb  = r_out_strb;
  assign bus.word_valid = r_out_valid;
  assign bus.byte_cnt   = r_cnt;

endmodule
